// File: rtl/pio_irq_pkg.sv
// Shared definitions for the PIO interrupt-servicing initiator:
// FSM state encoding, PIO register indices and Avalon-MM command helpers.
package pio_irq_pkg;

   // Bus sequencer states
   typedef enum logic [2:0] {
      StInitMask,
      StInitClr,
      StGuard,
      StIdle,
      StRead,
      StClear
   } state_e;

   // PIO register indices
   localparam logic [1:0] PIO_ADDR_DATA = 2'd0;
   localparam logic [1:0] PIO_ADDR_MASK = 2'd2;
   localparam logic [1:0] PIO_ADDR_EDGE = 2'd3;

   // One cycle worth of Avalon-MM initiator outputs
   typedef struct packed {
      logic        chipselect;
      logic        write_n;
      logic [1:0]  address;
      logic [31:0] writedata;
   } avm_cmd_t;

   // Bus parked: no strobe, write_n inactive, address/data at zero
   function automatic avm_cmd_t avm_idle();
      avm_cmd_t cmd;
      cmd.chipselect = 1'b0;
      cmd.write_n    = 1'b1;
      cmd.address    = PIO_ADDR_DATA;
      cmd.writedata  = 32'd0;
      return cmd;
   endfunction

   // Single-cycle register write
   function automatic avm_cmd_t avm_write(input logic [1:0] addr, input logic [31:0] data);
      avm_cmd_t cmd;
      cmd.chipselect = 1'b1;
      cmd.write_n    = 1'b0;
      cmd.address    = addr;
      cmd.writedata  = data;
      return cmd;
   endfunction

   // Register read strobe; held by the caller for the full read latency
   function automatic avm_cmd_t avm_read(input logic [1:0] addr);
      avm_cmd_t cmd;
      cmd.chipselect = 1'b1;
      cmd.write_n    = 1'b1;
      cmd.address    = addr;
      cmd.writedata  = 32'd0;
      return cmd;
   endfunction

endpackage

// File: rtl/pio_evt_slot.sv
// Single-entry event holding register. New captures either load the slot
// (empty or being accepted) or OR-merge into an unaccepted event, which
// raises a sticky overflow flag.
module pio_evt_slot
   import pio_irq_pkg::*;
#(
   parameter int unsigned DATA_W = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cap_valid,
   input  logic [DATA_W-1:0] cap_data,
   output logic              evt_valid,
   output logic [DATA_W-1:0] evt_data,
   input  logic              evt_ready,
   output logic              evt_overflow,
   input  logic              ovf_clr
);

   logic              valid_q, valid_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              ovf_q, ovf_d;
   logic              ovf_set;
   logic              accept;
   logic              new_cap;

   assign accept  = valid_q & evt_ready;
   // An all-zero capture is a spurious interrupt and leaves the slot untouched
   assign new_cap = cap_valid & (|cap_data);

   // Next-state for slot contents, handshake and overflow
   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      ovf_set = 1'b0;
      if (new_cap) begin
         if (!valid_q || accept) begin
            data_d  = cap_data;
            valid_d = 1'b1;
         end else begin
            data_d  = data_q | cap_data;
            ovf_set = 1'b1;
         end
      end else if (accept) begin
         // data is kept on accept; only valid drops
         valid_d = 1'b0;
      end
      // A merge in the same cycle as a clear request keeps the flag set
      if (ovf_set) begin
         ovf_d = 1'b1;
      end else if (ovf_clr) begin
         ovf_d = 1'b0;
      end else begin
         ovf_d = ovf_q;
      end
   end

   // Slot state registers
   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         ovf_q   <= 1'b0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
         ovf_q   <= ovf_d;
      end
   end

   assign evt_valid    = valid_q;
   assign evt_data     = data_q;
   assign evt_overflow = ovf_q;

endmodule

// File: rtl/pio_irq_master.sv
// Avalon-MM initiator that services a PIO edge-capture interrupt: programs
// the irq mask after reset, then on each interrupt reads and clears the
// edge-capture register and hands the captured bits to an event slot.
module pio_irq_master
   import pio_irq_pkg::*;
#(
   parameter int unsigned       DATA_W       = 2,
   parameter int unsigned       READ_LATENCY = 1,
   parameter logic [DATA_W-1:0] INIT_MASK    = {DATA_W{1'b1}}
) (
   input  logic              clk,
   input  logic              reset,
   output logic [1:0]        avm_address,
   output logic              avm_chipselect,
   output logic              avm_write_n,
   output logic [31:0]       avm_writedata,
   input  logic [31:0]       avm_readdata,
   input  logic              irq,
   output logic              evt_valid,
   output logic [DATA_W-1:0] evt_data,
   input  logic              evt_ready,
   output logic              evt_overflow,
   input  logic              ovf_clr
);

   localparam int unsigned RL    = (READ_LATENCY < 1) ? 1 : READ_LATENCY;
   localparam int unsigned CNT_W = (RL < 2) ? 1 : $clog2(RL + 1);
   localparam logic [CNT_W-1:0] RL_CNT = CNT_W'(RL);

   state_e            state_q;
   logic [CNT_W-1:0]  cnt_q;
   avm_cmd_t          bus_q;
   logic [DATA_W-1:0] cap_q;
   logic              cap_vld_q;

   // Each state drives the bus for the following cycle and picks its successor.
   // Reading readdata on the CLEAR edge samples the last READ bus cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= StInitMask;
         cnt_q     <= '0;
         bus_q     <= avm_idle();
         cap_q     <= '0;
         cap_vld_q <= 1'b0;
      end else begin
         cap_vld_q <= 1'b0;
         unique case (state_q)
            StInitMask: begin
               bus_q   <= avm_write(PIO_ADDR_MASK, 32'(INIT_MASK));
               state_q <= StInitClr;
            end
            StInitClr: begin
               bus_q   <= avm_write(PIO_ADDR_EDGE, 32'd0);
               state_q <= StGuard;
            end
            StGuard: begin
               // PIO irq still reflects the pre-clear captures for one cycle
               bus_q   <= avm_idle();
               state_q <= StIdle;
            end
            StIdle: begin
               bus_q <= avm_idle();
               cnt_q <= '0;
               if (irq) begin
                  state_q <= StRead;
               end
            end
            StRead: begin
               bus_q <= avm_read(PIO_ADDR_EDGE);
               if (cnt_q == RL_CNT) begin
                  state_q <= StClear;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            StClear: begin
               bus_q     <= avm_write(PIO_ADDR_EDGE, 32'd0);
               cap_q     <= avm_readdata[DATA_W-1:0];
               cap_vld_q <= 1'b1;
               state_q   <= StGuard;
            end
            default: begin
               bus_q   <= avm_idle();
               state_q <= StInitMask;
            end
         endcase
      end
   end

   assign avm_chipselect = bus_q.chipselect;
   assign avm_write_n    = bus_q.write_n;
   assign avm_address    = bus_q.address;
   assign avm_writedata  = bus_q.writedata;

   // Upper readdata bits carry nothing for a narrow PIO
   if (DATA_W < 32) begin : g_unused_rd
      logic unused_rd;
      assign unused_rd = ^avm_readdata[31:DATA_W];
   end

   // Event update lands at the end of the CLEAR bus cycle
   pio_evt_slot #(
      .DATA_W (DATA_W)
   ) u_evt_slot (
      .clk          (clk),
      .reset        (reset),
      .cap_valid    (cap_vld_q),
      .cap_data     (cap_q),
      .evt_valid    (evt_valid),
      .evt_data     (evt_data),
      .evt_ready    (evt_ready),
      .evt_overflow (evt_overflow),
      .ovf_clr      (ovf_clr)
   );

endmodule

// File: tb/tb_pio_irq_master.sv
// Directed bench for pio_irq_master with a small behavioural PIO attached.
module tb_pio_irq_master;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [1:0]  avm_address;
   logic        avm_chipselect;
   logic        avm_write_n;
   logic [31:0] avm_writedata;
   logic [31:0] avm_readdata;
   logic        irq;
   logic        evt_valid;
   logic [1:0]  evt_data;
   logic        evt_ready = 1'b0;
   logic        evt_overflow;
   logic        ovf_clr = 1'b0;

   // PIO model state
   logic [1:0]  in_port = 2'b00;
   logic [1:0]  in_prev = 2'b00;
   logic [1:0]  pio_mask = 2'b00;
   logic [1:0]  pio_edge = 2'b00;
   logic [31:0] rd_q = 32'd0;
   logic        force_irq = 1'b0;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   pio_irq_master #(
      .DATA_W       (2),
      .READ_LATENCY (1),
      .INIT_MASK    (2'b11)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .avm_address    (avm_address),
      .avm_chipselect (avm_chipselect),
      .avm_write_n    (avm_write_n),
      .avm_writedata  (avm_writedata),
      .avm_readdata   (avm_readdata),
      .irq            (irq),
      .evt_valid      (evt_valid),
      .evt_data       (evt_data),
      .evt_ready      (evt_ready),
      .evt_overflow   (evt_overflow),
      .ovf_clr        (ovf_clr)
   );

   // PIO: rising-edge capture, clear-all on write to 3, one-cycle read latency
   always @(posedge clk) begin
      in_prev <= in_port;
      if (avm_chipselect && !avm_write_n && avm_address == 2'd2)
         pio_mask <= avm_writedata[1:0];
      if (avm_chipselect && !avm_write_n && avm_address == 2'd3)
         pio_edge <= 2'b00;
      else
         pio_edge <= pio_edge | (in_port & ~in_prev);
      if (avm_chipselect && avm_write_n) begin
         case (avm_address)
            2'd0:    rd_q <= {30'd0, in_port};
            2'd2:    rd_q <= {30'd0, pio_mask};
            2'd3:    rd_q <= {30'd0, pio_edge};
            default: rd_q <= 32'd0;
         endcase
      end
   end

   assign avm_readdata = rd_q;
   assign irq = (|(pio_edge & pio_mask)) | force_irq;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Raise an interrupt (edge on in_port, or forced irq when bits==0), follow
   // the read and clear, and drive ready/ovf_clr during the clear cycle.
   task automatic service(input logic [1:0] bits, input logic rdy, input logic oclr,
                          input string tag);
      int n;
      if (bits != 2'b00) in_port = bits;
      else force_irq = 1'b1;
      tick();
      in_port   = 2'b00;
      force_irq = 1'b0;
      n = 0;
      while (!(avm_chipselect && avm_write_n) && n < 20) begin
         tick();
         n++;
      end
      check({tag, "_read_seen"}, 32'(n < 20), 32'd1);
      check({tag, "_read_addr"}, 32'(avm_address), 32'd3);
      n = 0;
      while (!(avm_chipselect && !avm_write_n) && n < 20) begin
         tick();
         n++;
      end
      check({tag, "_read_to_clear"}, 32'(n), 32'd2);
      check({tag, "_clear_addr"}, 32'(avm_address), 32'd3);
      check({tag, "_clear_data"}, avm_writedata, 32'd0);
      evt_ready = rdy;
      ovf_clr   = oclr;
      tick();
      evt_ready = 1'b0;
      ovf_clr   = 1'b0;
   endtask

   initial begin
      // Reset state
      tick();
      tick();
      check("rst_cs", 32'(avm_chipselect), 32'd0);
      check("rst_wn", 32'(avm_write_n), 32'd1);
      check("rst_addr", 32'(avm_address), 32'd0);
      check("rst_wd", avm_writedata, 32'd0);
      check("rst_valid", 32'(evt_valid), 32'd0);
      check("rst_data", 32'(evt_data), 32'd0);
      check("rst_ovf", 32'(evt_overflow), 32'd0);
      reset = 1'b0;

      // Init sequence: mask write, clear write, then idle
      tick();
      check("init_mask_cs", 32'({avm_chipselect, avm_write_n}), 32'b10);
      check("init_mask_addr", 32'(avm_address), 32'd2);
      check("init_mask_wd", avm_writedata, 32'd3);
      tick();
      check("init_clr_cs", 32'({avm_chipselect, avm_write_n}), 32'b10);
      check("init_clr_addr", 32'(avm_address), 32'd3);
      check("init_clr_wd", avm_writedata, 32'd0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("init_idle_cs", 32'(avm_chipselect), 32'd0);
      end
      check("init_valid", 32'(evt_valid), 32'd0);
      check("init_pio_mask", 32'(pio_mask), 32'd3);

      // Single edge, then accept
      service(2'b01, 1'b0, 1'b0, "t1");
      check("t1_valid", 32'(evt_valid), 32'd1);
      check("t1_data", 32'(evt_data), 32'd1);
      check("t1_ovf", 32'(evt_overflow), 32'd0);
      evt_ready = 1'b1;
      tick();
      evt_ready = 1'b0;
      check("t1_acc_valid", 32'(evt_valid), 32'd0);
      check("t1_acc_data_kept", 32'(evt_data), 32'd1);
      tick();

      // Two edges without accept; ovf_clr during the merge loses to set
      service(2'b01, 1'b0, 1'b0, "t2a");
      check("t2a_valid", 32'(evt_valid), 32'd1);
      check("t2a_data", 32'(evt_data), 32'd1);
      check("t2a_ovf", 32'(evt_overflow), 32'd0);
      service(2'b10, 1'b0, 1'b1, "t2b");
      check("t2b_valid", 32'(evt_valid), 32'd1);
      check("t2b_data", 32'(evt_data), 32'd3);
      check("t2b_ovf_set_wins", 32'(evt_overflow), 32'd1);
      ovf_clr = 1'b1;
      tick();
      ovf_clr = 1'b0;
      check("t2_ovf_clr", 32'(evt_overflow), 32'd0);
      check("t2_valid_kept", 32'(evt_valid), 32'd1);
      check("t2_data_kept", 32'(evt_data), 32'd3);

      // Accept in the same cycle as a new capture
      service(2'b10, 1'b1, 1'b0, "t3");
      check("t3_valid", 32'(evt_valid), 32'd1);
      check("t3_data", 32'(evt_data), 32'd2);
      check("t3_ovf", 32'(evt_overflow), 32'd0);
      evt_ready = 1'b1;
      tick();
      evt_ready = 1'b0;
      check("t3_acc_valid", 32'(evt_valid), 32'd0);
      tick();

      // Spurious irq: read returns zero, clear still issued, no event
      service(2'b00, 1'b0, 1'b0, "t4");
      check("t4_valid", 32'(evt_valid), 32'd0);
      check("t4_data", 32'(evt_data), 32'd2);
      check("t4_ovf", 32'(evt_overflow), 32'd0);
      tick();

      // Reset during READ
      in_port = 2'b01;
      tick();
      in_port = 2'b00;
      for (int i = 0; i < 20; i++) begin
         if (!(avm_chipselect && avm_write_n)) tick();
      end
      check("t5_read_seen", 32'({avm_chipselect, avm_write_n}), 32'b11);
      reset = 1'b1;
      tick();
      check("t5_rst_cs", 32'(avm_chipselect), 32'd0);
      check("t5_rst_wn", 32'(avm_write_n), 32'd1);
      tick();
      reset = 1'b0;
      tick();
      check("t5_mask_addr", 32'({avm_chipselect, avm_write_n, avm_address}), 32'b1010);
      tick();
      check("t5_clr_addr", 32'({avm_chipselect, avm_write_n, avm_address}), 32'b1011);
      for (int i = 0; i < 4; i++) begin
         tick();
         check("t5_idle_cs", 32'(avm_chipselect), 32'd0);
      end
      check("t5_valid", 32'(evt_valid), 32'd0);
      check("t5_pio_edge", 32'(pio_edge), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
